puf_eval_ctrl: RTL and testbench

Parametrised challenge/response evaluation controller for the arbiter-PUF family (LSPUF, IPUF). Latches a CW-bit challenge, drives it and the shared trigger (`tigSignal`) into NCH external delay-chain/arbiter channels, and samples the arbiter outputs after a programmable settle time. Repeats the evaluation NVOTE times with majority voting, then presents per-channel response bits, their XOR and a per-channel stability flag behind a ready pulse. Sits between the UART/host challenge interface and the PUF delay-line instances.

---
 rtl/puf_eval_ctrl.sv | 131 +++++++++++++
 tb/tb_puf_eval_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: challenge/response evaluation controller for arbiter-PUF delay-chain channels.
// Build option PUF_VOTE_EN: NVOTE-fold majority voting with per-channel stability; otherwise one evaluation.
module puf_eval_ctrl #(
  parameter int CW     = 64,
  parameter int NCH    = 4,
  parameter int SETTLE = 8,
  parameter int NVOTE  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  c,
  output logic [CW-1:0]  pufChal,
  output logic           tigSignal,
  input  logic [NCH-1:0] arbResp,
  output logic           busy,
  output logic           respReady,
  output logic [NCH-1:0] respBits,
  output logic           respXor,
  output logic [NCH-1:0] respStable
);

`ifdef PUF_VOTE_EN
  localparam int NV = NVOTE;
`else
  localparam int NV = 1;
`endif
  localparam int PW = $clog2(SETTLE + 1);
  localparam int EW = $clog2(NV + 1);

  if (NCH < 1 || NCH > 32 || SETTLE < 1 || NVOTE < 1 || (NVOTE % 2) == 0) begin : g_param_check
    $error("puf_eval_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, SAMPLE, RELAX, DONE} state_t;

  state_t         state, nextState;
  logic [PW-1:0]  phaseCnt;
  logic [EW-1:0]  evalCnt;
  logic           phaseEnd, accept, enterDone;
  logic [NCH-1:0] voteBits, voteStable;

  assign phaseEnd  = (phaseCnt == PW'(SETTLE - 1));
  assign accept    = (state == IDLE) && start;
  assign enterDone = (state == RELAX) && (nextState == DONE);

  // NOTE: every clocked block uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // NOTE: nextState takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD:    nextState = FIRE;
      FIRE:    if (phaseEnd) nextState = SAMPLE;
      SAMPLE:  nextState = RELAX;
      RELAX:   if (phaseEnd) nextState = (evalCnt < EW'(NV)) ? FIRE : DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    tigSignal = (state == FIRE) || (state == SAMPLE);
    busy      = (state != IDLE);
    respReady = (state == DONE);
  end

  // Phase timer restarts on every state change; only FIRE and RELAX ever reach phaseEnd.
  always_ff @(posedge clk) begin
    if (rst) begin
      phaseCnt   <= '0;
      evalCnt    <= '0;
      pufChal    <= '0;
      respBits   <= '0;
      respXor    <= 1'b0;
      respStable <= '0;
    end else begin
      if (state != nextState)                 phaseCnt <= '0;
      else if (state == FIRE || state == RELAX) phaseCnt <= phaseCnt + PW'(1);

      if (accept)               evalCnt <= '0;
      else if (state == SAMPLE) evalCnt <= evalCnt + EW'(1);

      if (accept) pufChal <= c;

      if (enterDone) begin
        respBits   <= voteBits;
        respXor    <= ^voteBits;
        respStable <= voteStable;
      end
    end
  end

`ifdef PUF_VOTE_EN
  logic [EW-1:0] onesCnt [NCH];

  // NOTE: the ones-counters are a few flops per channel, not a RAM, so they take the reset like any register.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int i = 0; i < NCH; i++) onesCnt[i] <= '0;
    end else if (state == SAMPLE) begin
      for (int i = 0; i < NCH; i++) onesCnt[i] <= onesCnt[i] + EW'(arbResp[i]);
    end
  end

  always_comb begin
    voteBits   = '0;
    voteStable = '0;
    for (int i = 0; i < NCH; i++) begin
      voteBits[i]   = (onesCnt[i] > EW'(NV / 2));
      voteStable[i] = (onesCnt[i] == '0) || (onesCnt[i] == EW'(NV));
    end
  end
`else
  logic [NCH-1:0] sampleBits;

  always_ff @(posedge clk) begin
    if (rst)                  sampleBits <= '0;
    else if (state == SAMPLE) sampleBits <= arbResp;
  end

  assign voteBits   = sampleBits;
  assign voteStable = '1;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: scoreboard bench for puf_eval_ctrl with directed challenge/response vectors.
// Expected results follow the PUF_VOTE_EN build option, exactly as the RTL does.
module tb_puf_eval_ctrl;

  localparam int S = 8;
`ifdef PUF_VOTE_EN
  localparam int NV = 5;
  localparam logic [3:0] NOISY_BITS = 4'b0001, NOISY_STABLE = 4'b1110;
  localparam logic [3:0] MIX_BITS   = 4'b0100, MIX_STABLE   = 4'b0100;
  localparam logic       MIX_XOR    = 1'b1;
`else
  localparam int NV = 1;
  localparam logic [3:0] NOISY_BITS = 4'b0001, NOISY_STABLE = 4'b1111;
  localparam logic [3:0] MIX_BITS   = 4'b1100, MIX_STABLE   = 4'b1111;
  localparam logic       MIX_XOR    = 1'b0;
`endif
  localparam int P    = 2 * S + 1;
  localparam int LAT  = 1 + NV * P;
  localparam int LATB = 1 + NV * 5;
  localparam logic [63:0] BASE = 64'h5a5a_0000_c3c3_0000;

  typedef logic [3:0] vec_t [5];
  typedef struct {
    logic [3:0] bits;
    logic       xr;
    logic [3:0] stable;
    int         cycle;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] c = '0;
  logic [3:0]  arbResp = '0;
  logic [63:0] pufChal;
  logic        tigSignal, busy, respReady, respXor;
  logic [3:0]  respBits, respStable;

  logic        startB = 1'b0;
  logic [63:0] cB = '0;
  logic [3:0]  arbB = '0;
  logic [63:0] pufChalB;
  logic        tigB, busyB, respReadyB, respXorB;
  logic [3:0]  respBitsB, respStableB;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  exp_t sb[$];
  exp_t monItem;

  puf_eval_ctrl #(.CW(64), .NCH(4), .SETTLE(S), .NVOTE(5)) dut (
    .clk(clk), .rst(rst), .start(start), .c(c), .pufChal(pufChal), .tigSignal(tigSignal),
    .arbResp(arbResp), .busy(busy), .respReady(respReady), .respBits(respBits),
    .respXor(respXor), .respStable(respStable)
  );

  puf_eval_ctrl #(.CW(64), .NCH(4), .SETTLE(2), .NVOTE(5)) dutB (
    .clk(clk), .rst(rst), .start(startB), .c(cB), .pufChal(pufChalB), .tigSignal(tigB),
    .arbResp(arbB), .busy(busyB), .respReady(respReadyB), .respBits(respBitsB),
    .respXor(respXorB), .respStable(respStableB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || respReady) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
    end
  endtask

  // Scoreboard monitor: every respReady pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (respReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_respReady: pulse with nothing outstanding (cycle %0d)", cyc);
      end else begin
        monItem = sb.pop_front();
        check("ready_cycle", 64'(cyc), 64'(monItem.cycle));
        check("respBits", 64'(respBits), 64'(monItem.bits));
        check("respXor", 64'(respXor), 64'(monItem.xr));
        check("respStable", 64'(respStable), 64'(monItem.stable));
      end
    end
  end

  task automatic runEval(input logic [63:0] ch, input vec_t vec, input bit chkTig,
                         input logic [3:0] eb, input logic ex, input logic [3:0] es);
    int a;
    c = ch;
    arbResp = vec[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc;
    sb.push_back(exp_t'{eb, ex, es, a + LAT});
    check("pufChal_accept", pufChal, ch);
    check("busy_accept", 64'(busy), 64'(1'b1));
    c = ~ch;
    if (chkTig) begin
      check("tig_load", 64'(tigSignal), 64'(1'b0));
      waitCyc(a + 1);
      check("tig_fire", 64'(tigSignal), 64'(1'b1));
      waitCyc(a + 1 + S);
      check("tig_sample", 64'(tigSignal), 64'(1'b1));
      waitCyc(a + 2 + S);
      check("tig_relax", 64'(tigSignal), 64'(1'b0));
    end
    for (int k = 1; k < NV; k++) begin
      waitCyc(a + 2 + k * P);
      arbResp = vec[k];
    end
    waitIdle();
    check("pufChal_held", pufChal, ch);
  endtask

  initial begin
    vec_t        v;
    int          m0, a1, a2, a, aB, n, chalErr, kr;
    logic [63:0] chal1, chal2;

    rst = 1'b1;
    start = 1'b1;
    c = 64'hdead_beef_0123_4567;
    repeat (3) begin
      @(negedge clk);
      check("rst_tig", 64'(tigSignal), 64'(1'b0));
      check("rst_busy", 64'(busy), 64'(1'b0));
      check("rst_ready", 64'(respReady), 64'(1'b0));
      check("rst_pufChal", pufChal, 64'h0);
      check("rst_results", 64'({respBits, respXor, respStable}), 64'h0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    v = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    runEval(64'h0afbaafbaafbaafb, v, 1'b1, 4'b1010, 1'b0, 4'b1111);

    v = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    runEval(64'h1111_2222_3333_4444, v, 1'b0, NOISY_BITS, 1'b1, NOISY_STABLE);

    v = '{4'b1100, 4'b0101, 4'b1111, 4'b0100, 4'b0110};
    runEval(64'hffff_0000_ffff_0001, v, 1'b0, MIX_BITS, MIX_XOR, MIX_STABLE);

    v = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    runEval(64'h8000_0000_0000_0000, v, 1'b0, 4'b0000, 1'b0, 4'b1111);

    // start held high with c changing every cycle: back-to-back evaluations, challenge latched only on accept
    arbResp = 4'b0110;
    m0 = cyc;
    c = BASE ^ 64'(m0);
    start = 1'b1;
    a1 = m0 + 1;
    a2 = a1 + LAT + 2;
    chal1 = BASE ^ 64'(m0);
    chal2 = BASE ^ 64'(a2 - 1);
    sb.push_back(exp_t'{4'b0110, 1'b0, 4'b1111, a1 + LAT});
    sb.push_back(exp_t'{4'b0110, 1'b0, 4'b1111, a2 + LAT});
    chalErr = 0;
    while (cyc < a2 + LAT + 1) begin
      @(negedge clk);
      if (pufChal !== ((cyc < a2) ? chal1 : chal2)) chalErr++;
      if (cyc == a1 + LAT + 1) check("held_idle_gap", 64'(busy), 64'(1'b0));
      if (cyc == a2) check("held_reaccept", 64'(busy), 64'(1'b1));
      if (cyc == a2 + LAT) start = 1'b0;
      c = BASE ^ 64'(cyc);
    end
    check("held_pufChal_only_on_accept", 64'(chalErr), 64'h0);
    waitIdle();

    // abort during the third FIRE phase (first FIRE when only one evaluation exists)
    kr = (NV >= 3) ? 2 : 0;
    c = 64'h0123_4567_89ab_cdef;
    arbResp = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc;
    waitCyc(a + 1 + kr * P + 2);
    check("abort_in_fire", 64'(tigSignal), 64'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check("abort_tig", 64'(tigSignal), 64'(1'b0));
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_pufChal", pufChal, 64'h0);
    check("abort_results", 64'({respBits, respXor, respStable}), 64'h0);
    rst = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    v = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    runEval(64'hcafe_f00d_0000_0007, v, 1'b1, 4'b0111, 1'b1, 4'b1111);

    // short settle instance: latency and result of the reduced timing
    cB = 64'h0000_0000_1234_5678;
    arbB = 4'b0011;
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    aB = cyc;
    check("B_pufChal", pufChalB, 64'h0000_0000_1234_5678);
    n = 0;
    while (!respReadyB && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL B_ready_timeout: no respReady within %0d cycles", n);
    end else begin
      check("B_ready_cycle", 64'(cyc), 64'(aB + LATB));
      check("B_respBits", 64'(respBitsB), 64'(4'b0011));
      check("B_respXor", 64'(respXorB), 64'(1'b0));
      check("B_respStable", 64'(respStableB), 64'(4'b1111));
    end
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
